// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, FSM state type and size helpers for the memory stage.
// Items: SZ_* funct3 size/sign codes, state_t (IDLE/WAIT), is_byte/is_half size classifiers.
package mem_pkg;
    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic is_byte(input logic [2:0] size);
        return size == SZ_B || size == SZ_BU;
    endfunction

    function automatic logic is_half(input logic [2:0] size);
        return size == SZ_H || size == SZ_HU;
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for stores and extraction/extension for loads.
// Ports: size (funct3 code), addr (low address bits), store_data (rs2), rdata (bus word)
//        -> wstrb (store lane enables), wdata (replicated store data), load_data (extended load value).
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       size,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] rdata,
    output logic [3:0]       wstrb,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfwords only look at addr[1]; addr[0] is either trapped upstream or ignored.
    always_comb begin
        byte_v    = rdata[{addr, 3'b000} +: 8];
        half_v    = addr[1] ? rdata[31:16] : rdata[15:0];
        wstrb     = is_byte(size) ? 4'b0001 << addr :
                    is_half(size) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata     = is_byte(size) ? {4{store_data[7:0]}} :
                    is_half(size) ? {2{store_data[15:0]}} : store_data;
        load_data = size == SZ_B  ? {{(WIDTH-8){byte_v[7]}}, byte_v} :
                    size == SZ_BU ? {{(WIDTH-8){1'b0}}, byte_v} :
                    size == SZ_H  ? {{(WIDTH-16){half_v[15]}}, half_v} :
                    size == SZ_HU ? {{(WIDTH-16){1'b0}}, half_v} : rdata;
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: RV32I memory stage with a single-outstanding req/ack data bus and upstream stall.
// Ports: clk, reset (sync, active-high), halt; execute inputs i_rd/i_rd_sel/i_pc/i_mem_wr_en/
//        i_mem_rd_en/i_mem_wr_data/i_mem_rw_size; writeback o_rd/o_rd_sel/o_pc/o_misaligned;
//        o_stall; bus dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_wstrb/dmem_ack/dmem_rdata.
// Build option: MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into a one-cycle o_misaligned
// pulse with no bus request; otherwise offending low address bits are ignored.
module memory_access
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic [WIDTH-1:0] i_rd,
    input  logic [WIDTH-1:0] i_rd_sel,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_mem_wr_en,
    input  logic             i_mem_rd_en,
    input  logic [WIDTH-1:0] i_mem_wr_data,
    input  logic [2:0]       i_mem_rw_size,
    output logic             o_stall,
    output logic [WIDTH-1:0] o_rd,
    output logic [WIDTH-1:0] o_rd_sel,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_misaligned,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata
);
    state_t           state;
    logic [2:0]       lat_size;
    logic [1:0]       lat_a;
    logic [WIDTH-1:0] lat_rd_sel;
    logic [WIDTH-1:0] lat_pc;
    logic             lat_load;
    logic             mem_op;
    logic             mis;
    logic [3:0]       al_wstrb;
    logic [WIDTH-1:0] al_wdata;
    logic [WIDTH-1:0] al_load;

    assign mem_op = i_mem_rd_en | i_mem_wr_en;

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = mem_op & (is_half(i_mem_rw_size) ? i_rd[0] :
                           !is_byte(i_mem_rw_size) && i_rd[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign o_stall = (state == IDLE && mem_op && !mis) || (state == WAIT && !dmem_ack);

    // One aligner serves both phases: issue uses the live inputs, WAIT the latched access.
    mem_lane_align #(.WIDTH(WIDTH)) u_align (
        .size       (state == WAIT ? lat_size : i_mem_rw_size),
        .addr       (state == WAIT ? lat_a : i_rd[1:0]),
        .store_data (i_mem_wr_data),
        .rdata      (dmem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_size     <= '0;
            lat_a        <= '0;
            lat_rd_sel   <= '0;
            lat_pc       <= '0;
            lat_load     <= 1'b0;
            o_rd         <= '0;
            o_rd_sel     <= '0;
            o_pc         <= '0;
            o_misaligned <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= '0;
        end else begin
            o_misaligned <= 1'b0;
            if (state == IDLE) begin
                if (!halt && !mem_op) begin
                    o_rd     <= i_rd;
                    o_rd_sel <= i_rd_sel;
                    o_pc     <= i_pc;
                end else if (!halt && mis) begin
                    o_misaligned <= 1'b1;
                    o_rd         <= i_rd;
                    o_rd_sel     <= '0;
                    o_pc         <= i_pc;
                end else if (!halt) begin
                    lat_size   <= i_mem_rw_size;
                    lat_a      <= i_rd[1:0];
                    lat_rd_sel <= i_rd_sel;
                    lat_pc     <= i_pc;
                    lat_load   <= !i_mem_wr_en;
                    dmem_req   <= 1'b1;
                    dmem_we    <= i_mem_wr_en;
                    dmem_addr  <= {i_rd[WIDTH-1:2], 2'b00};
                    dmem_wdata <= al_wdata;
                    dmem_wstrb <= i_mem_wr_en ? al_wstrb : 4'b0000;
                    state      <= WAIT;
                end
            end else if (dmem_ack) begin
                dmem_req <= 1'b0;
                state    <= IDLE;
                o_rd     <= lat_load ? al_load : '0;
                o_rd_sel <= lat_load ? lat_rd_sel : '0;
                o_pc     <= lat_pc;
            end
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized scoreboard bench for memory_access with a byte-level memory model.
module tb_memory_access;
    logic        clk = 1'b0;
    logic        reset, halt;
    logic [31:0] i_rd, i_rd_sel, i_pc, i_mem_wr_data;
    logic        i_mem_wr_en, i_mem_rd_en;
    logic [2:0]  i_mem_rw_size;
    logic        o_stall, o_misaligned, dmem_req, dmem_we, dmem_ack;
    logic [31:0] o_rd, o_rd_sel, o_pc, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        r_ack = 1'b0, m_ack = 1'b0;

    assign dmem_ack = r_ack | m_ack;

    memory_access #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .i_rd(i_rd), .i_rd_sel(i_rd_sel), .i_pc(i_pc),
        .i_mem_wr_en(i_mem_wr_en), .i_mem_rd_en(i_mem_rd_en),
        .i_mem_wr_data(i_mem_wr_data), .i_mem_rw_size(i_mem_rw_size),
        .o_stall(o_stall), .o_rd(o_rd), .o_rd_sel(o_rd_sel), .o_pc(o_pc),
        .o_misaligned(o_misaligned), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] rd, sel, pc; logic mis;} wb_t;
    typedef struct {logic [31:0] addr, wdata; logic we; logic [3:0] strb;} bus_t;

    wb_t         wbq[$];
    bus_t        busq[$];
    logic [31:0] smem[256];
    logic [31:0] rmem[256];
    int          total = 0, bad = 0;
    bit          resp_en = 0, mon_en = 0;
    int          force_dly = -1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        return (sz == 3'd0 || sz == 3'd4) ? 1 : (sz == 3'd1 || sz == 3'd5) ? 2 : 4;
    endfunction

    function automatic bit trap(input logic [2:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return nbytes(sz) == 2 ? a[0] : nbytes(sz) == 4 ? (a[1:0] != 2'b00) : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: lane offset, store byte merge and load extension from plain arithmetic.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] data, input logic [31:0] sel, input logic [31:0] pc,
                          output int stalls);
        wb_t w;
        bus_t b;
        int n, o, c;
        logic [31:0] word, v, m;
        @(negedge clk);
        halt = 0; i_rd = a; i_rd_sel = sel; i_pc = pc; i_mem_rd_en = ld; i_mem_wr_en = st;
        i_mem_wr_data = data; i_mem_rw_size = sz;
        n = nbytes(sz);
        o = n == 1 ? int'(a[1:0]) : n == 2 ? int'(a[1:0]) & 2 : 0;
        if (!ld && !st) w = '{a, sel, pc, 1'b0};
        else if (trap(sz, a)) w = '{a, 32'd0, pc, 1'b1};
        else begin
            b.addr = a & ~32'd3; b.we = st; b.strb = 4'b0; b.wdata = 32'd0;
            if (st) begin
                for (int j = 0; j < 4; j++) begin
                    b.wdata[8*j +: 8] = data[8*(j % n) +: 8];
                    if (j >= o && j < o + n) begin
                        b.strb[j] = 1'b1;
                        rmem[a[9:2]][8*j +: 8] = data[8*(j-o) +: 8];
                    end
                end
                w = '{32'd0, 32'd0, pc, 1'b0};
            end else begin
                word = rmem[a[9:2]];
                m = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8*n)) - 32'd1;
                v = (word >> (8*o)) & m;
                if (sz < 3'd4 && n < 4 && v[8*n-1]) v = v | ~m;
                w = '{v, sel, pc, 1'b0};
            end
            busq.push_back(b);
        end
        wbq.push_back(w);
        #1 chk("stall_issue", {31'd0, o_stall}, {31'd0, (ld || st) && !trap(sz, a)});
        stalls = o_stall ? 1 : 0;
        c = 0;
        while (o_stall && c < 40) begin
            @(negedge clk); #1;
            if (o_stall) stalls++;
            c++;
        end
        if (o_stall) begin
            total++; bad++;
            $display("FAIL ack_timeout: stall still %b after %0d cycles, required 0", o_stall, c);
        end
    endtask

    // Bus responder: checks each new request against the model, then acks after a delay.
    initial begin
        int dly;
        bit busy;
        bus_t b;
        busy = 0; dly = 0; dmem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (r_ack) begin r_ack = 1'b0; continue; end
            if (!resp_en || !dmem_req) continue;
            if (!busy) begin
                busy = 1;
                dly = force_dly >= 0 ? force_dly : int'($urandom_range(0, 3));
                force_dly = -1;
                if (busq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bus_unexpected: request at %h, none required", dmem_addr);
                end else begin
                    b = busq.pop_front();
                    chk("bus_addr", dmem_addr, b.addr);
                    chk("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
                    chk("bus_wstrb", {28'd0, dmem_wstrb}, {28'd0, b.strb});
                    if (b.we) chk("bus_wdata", dmem_wdata, b.wdata);
                end
            end
            if (dly == 0) begin
                if (dmem_we) begin
                    for (int j = 0; j < 4; j++)
                        if (dmem_wstrb[j]) smem[dmem_addr[9:2]][8*j +: 8] = dmem_wdata[8*j +: 8];
                end else dmem_rdata = smem[dmem_addr[9:2]];
                r_ack = 1'b1;
                busy = 0;
            end else dly--;
        end
    end

    // Writeback monitor: a cycle with no stall, halt or reset retires one instruction.
    logic        m_fire;
    logic [31:0] p_rd, p_sel, p_pc;
    initial begin
        wb_t w;
        forever begin
            @(negedge clk); #2;
            m_fire = mon_en && !reset && !halt && !o_stall;
            p_rd = o_rd; p_sel = o_rd_sel; p_pc = o_pc;
            @(posedge clk); #1;
            if (!mon_en) continue;
            if (m_fire) begin
                if (wbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected: writeback rd=%h, none required", o_rd);
                end else begin
                    w = wbq.pop_front();
                    chk("wb_rd", o_rd, w.rd);
                    chk("wb_sel", o_rd_sel, w.sel);
                    chk("wb_pc", o_pc, w.pc);
                    chk("wb_mis", {31'd0, o_misaligned}, {31'd0, w.mis});
                end
            end else begin
                chk("hold_rd", o_rd, p_rd);
                chk("hold_sel", o_rd_sel, p_sel);
                chk("hold_pc", o_pc, p_pc);
                chk("hold_mis", {31'd0, o_misaligned}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, pc;
        logic [2:0] sz;
        logic [31:0] a;
        int kind;
        pc = 32'h1000;
        for (int k = 0; k < 256; k++) begin
            smem[k] = $urandom;
            rmem[k] = smem[k];
        end
        smem[0] = 32'h80FF7F01; rmem[0] = 32'h80FF7F01;
        reset = 1; halt = 1; i_rd = 0; i_rd_sel = 0; i_pc = 0; i_mem_wr_en = 0; i_mem_rd_en = 0;
        i_mem_wr_data = 0; i_mem_rw_size = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd", o_rd, 0); chk("rst_sel", o_rd_sel, 0); chk("rst_pc", o_pc, 0);
        chk("rst_req", {31'd0, dmem_req}, 0); chk("rst_mis", {31'd0, o_misaligned}, 0);
        chk("rst_wstrb", {28'd0, dmem_wstrb}, 0); chk("rst_addr", dmem_addr, 0);
        reset = 0; mon_en = 1; resp_en = 1;

        run_op(0, 0, 3'd2, 32'h1234, 0, 5, pc, st);
        @(posedge clk); #1;
        chk("alu_rd", o_rd, 32'h1234); chk("alu_sel", o_rd_sel, 5);

        force_dly = 2;
        run_op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 9, pc + 4, st);
        chk("sw_stall_cycles", st, 3);
        chk("sw_addr", dmem_addr, 32'h100); chk("sw_wstrb", {28'd0, dmem_wstrb}, 32'hF);
        @(posedge clk); #1;
        chk("sw_sel", o_rd_sel, 0);

        run_op(0, 1, 3'd0, 32'h203, 32'h000000A5, 3, pc + 8, st);
        chk("sb_wstrb", {28'd0, dmem_wstrb}, 32'h8); chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);

        run_op(1, 0, 3'd0, 32'h3, 0, 7, pc + 12, st);
        @(posedge clk); #1; chk("lb_rd", o_rd, 32'hFFFFFF80); chk("lb_sel", o_rd_sel, 7);
        run_op(1, 0, 3'd4, 32'h3, 0, 7, pc + 16, st);
        @(posedge clk); #1; chk("lbu_rd", o_rd, 32'h80);
        run_op(1, 0, 3'd1, 32'h2, 0, 7, pc + 20, st);
        @(posedge clk); #1; chk("lh_rd", o_rd, 32'hFFFF80FF);
        run_op(1, 0, 3'd2, 32'h0, 0, 7, pc + 24, st);
        @(posedge clk); #1; chk("lw_rd", o_rd, 32'h80FF7F01);

        run_op(1, 0, 3'd2, 32'h102, 0, 7, pc + 28, st);
`ifdef MEM_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        chk("trap_mis", {31'd0, o_misaligned}, 1); chk("trap_sel", o_rd_sel, 0);
        chk("trap_req", {31'd0, dmem_req}, 0);
`else
        chk("lw_mis_addr", dmem_addr, 32'h100);
        @(posedge clk); #1; chk("lw_mis_rd", o_rd, 32'hDEADBEEF);
`endif

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                halt = 1; i_mem_rd_en = 0; i_mem_wr_en = 0; i_rd = $urandom;
            end
            kind = $urandom_range(0, 9);
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 1023));
            pc = pc + 4;
            if (kind < 4) run_op(0, 0, 3'($urandom), $urandom, $urandom, $urandom_range(0, 31), pc, st);
            else if (kind < 7) run_op(1, 0, 3'($urandom), a, $urandom, $urandom_range(0, 31), pc, st);
            else run_op(0, 1, 3'($urandom_range(0, 2)), a, $urandom, $urandom_range(0, 31), pc, st);
        end

        @(negedge clk);
        halt = 1; i_mem_rd_en = 0; i_mem_wr_en = 0;
        repeat (3) @(negedge clk);
        chk("wbq_empty", 32'(wbq.size()), 0);
        chk("busq_empty", 32'(busq.size()), 0);

        mon_en = 0; resp_en = 0;
        @(negedge clk);
        halt = 0; i_rd = 32'h40; i_rd_sel = 3; i_pc = 32'h2000; i_mem_rd_en = 1; i_mem_rw_size = 3'd2;
        @(negedge clk); #1;
        chk("rw_req", {31'd0, dmem_req}, 1);
        reset = 1;
        @(negedge clk);
        reset = 0; halt = 1; i_mem_rd_en = 0; m_ack = 1'b1;
        #1;
        chk("rw_req_cleared", {31'd0, dmem_req}, 0);
        chk("rw_stall", {31'd0, o_stall}, 0);
        @(negedge clk);
        m_ack = 1'b0;
        #1;
        chk("rw_rd", o_rd, 0); chk("rw_sel", o_rd_sel, 0); chk("rw_pc", o_pc, 0);
        chk("rw_req_late", {31'd0, dmem_req}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
